fp_addsub_main: RTL and testbench
=================================

# fp_addsub_main

Single-precision floating-point add/subtract datapath core. It accepts two operands as separate sign, 8-bit exponent and 23-bit fraction fields plus an opcode. It produces a normalized 24-bit significand (hidden bit included), result sign, result exponent and the raw significand carry-out. The core sits in the fp_add lab datapath and registers its result one clock after the operands are presented.

## Interface
- Parameters: none.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- sa  input  1  sign of operand A.
- sb  input  1  sign of operand B.
- opcode  input  1  0 = A+B, 1 = A−B.
- ma  input  23  fraction of A.
- mb  input  23  fraction of B.
- ea  input  8  biased exponent of A.
- eb  input  8  biased exponent of B.
- mant  output  24  normalized result significand; bit 23 is the hidden bit.
- sign  output  1  result sign.
- exponent  output  8  result biased exponent.
- totalcarry  output  1  carry out of the 24-bit significand addition.

## Operation
- Significand forming: SA = {ea≠0, ma}; SB = {eb≠0, mb}. A zero exponent gives hidden bit 0 (denormal).
- ea=255 and eb=255 are treated as ordinary finite values. There is no NaN or Inf decoding.
- Effective sign of B: sbe = sb ^ opcode. Effective operation: sub = sa ^ sbe.
- Magnitude compare uses {e, S}. The larger operand is L and the smaller is S. On a tie, A is L.
- emax is L's exponent. d = eL − eS.
- Align: S is shifted right by d. Shifted-out bits are truncated. If d ≥ 24, S becomes 0.
- Add path (sub=0):
  - 25-bit sum = L + S_aligned. totalcarry = sum[24].
  - If the carry is set: mant = sum[24:1] and exponent = emax+1.
  - Otherwise: mant = sum[23:0] and exponent = emax.
  - sign = sa.
- Sub path (sub=1):
  - diff = L − S_aligned, which is always non-negative. totalcarry = 0.
  - sign is the effective sign of L.
  - Normalize: z = leading-zero count of diff (0..24). Shift = min(z, emax) when emax>0.
  - mant = diff << shift. exponent = emax − shift.
  - If emax − z < 0, the result clamps to exponent 0 (denormal).
- Zero result (mant==0 after either path): mant=0, exponent=0, sign=0, totalcarry as computed.

## Timing
- All four outputs are registered on the rising edge of clk.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- A new operation can be issued every cycle. There is no handshake.
- While rst=1, outputs are held immediately (asynchronously) at mant=0, sign=0, exponent=0, totalcarry=0.
- Reset asserted mid-operation discards the in-flight result.
- The first result after reset deassertion is available one edge after deassertion.

## Configuration
- Macro: FP_OVF_SAT_EN.
- Defined: if the add path gives emax+1 > 254, the output is exponent=8'hFF, mant=24'h000000, with sign and totalcarry unchanged (infinity).
- Undefined: exponent wraps modulo 256 and mant is left as computed.

## Test plan
- Add with carry: sa=sb=0, opcode=0, ma=23'h400000, mb=0, ea=eb=1.
  - Required after 1 clk: mant=24'hA00000, exponent=2, sign=0, totalcarry=1.
- Alignment: sa=sb=0, opcode=0, ma=mb=0, ea=3, eb=1.
  - Required: mant=24'hA00000, exponent=3, sign=0, totalcarry=0.
- Subtract with normalize, both orderings:
  - ea=eb=5, ma=23'h400000, mb=0, opcode=1 → mant=24'h800000, exponent=4, sign=0.
  - Operands swapped (ma=0, mb=23'h400000) → same mant and exponent, sign=1.
- Exact cancellation: ma=mb=23'h123456, ea=eb=7, opcode=1.
  - Required: mant=0, exponent=0, sign=0, totalcarry=0.
- Overflow: ea=eb=254, ma=mb=0, add.
  - With FP_OVF_SAT_EN: exponent=8'hFF, mant=0, totalcarry=1.
  - Without it: exponent=8'hFF, mant=24'h800000.
- Reset: assert rst between two issued operations.
  - Outputs go to 0 without waiting for a clock edge.
  - After release, the next sampled operation appears 1 cycle later.

Source files
------------

// File: rtl/fp_addsub_main_if.sv
// Operand/result bundle for fp_addsub_main: the master drives operands and reads results,
// and the slave (the datapath core) does the reverse.
interface fp_addsub_main_if;
  logic        sa;
  logic        sb;
  logic        opcode;
  logic [22:0] ma;
  logic [22:0] mb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] mant;
  logic        sign;
  logic [7:0]  exponent;
  logic        totalcarry;

  modport master (
    output sa, sb, opcode, ma, mb, ea, eb,
    input  mant, sign, exponent, totalcarry
  );

  modport slave (
    input  sa, sb, opcode, ma, mb, ea, eb,
    output mant, sign, exponent, totalcarry
  );
endinterface

// File: rtl/fp_addsub_main.sv
// Single-precision add/subtract datapath with a one-cycle registered result.
// Optional macro FP_OVF_SAT_EN saturates add-path exponent overflow to infinity.
module fp_addsub_main (
  input  logic                  clk,
  input  logic                  rst,
  fp_addsub_main_if.slave       bus
);

  // Leading-zero count of a 24-bit significand; an all-zero input returns 24.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic        sbe_s;
  logic        sub_s;
  logic [23:0] sig_a_s;
  logic [23:0] sig_b_s;
  logic        a_is_l_s;
  logic [23:0] sig_l_s;
  logic [23:0] sig_sm_s;
  logic [7:0]  emax_s;
  logic [7:0]  emin_s;
  logic [7:0]  dexp_s;
  logic [23:0] sig_al_s;
  logic        sign_l_s;
  logic [24:0] sum_s;
  logic [23:0] diff_s;
  logic [4:0]  lz_s;
  logic [7:0]  shift_s;
  logic [23:0] res_mant_s;
  logic [7:0]  res_exp_s;
  logic        res_sign_s;
  logic        res_tc_s;

  logic [23:0] mant_d,  mant_q;
  logic [7:0]  exp_d,   exp_q;
  logic        sign_d,  sign_q;
  logic        tc_d,    tc_q;

  // Operand ordering and alignment of the smaller significand.
  always_comb begin
    sbe_s   = bus.sb ^ bus.opcode;
    sub_s   = bus.sa ^ sbe_s;
    sig_a_s = {(bus.ea != 8'd0), bus.ma};
    sig_b_s = {(bus.eb != 8'd0), bus.mb};
    // Ties keep A as the larger operand.
    a_is_l_s = ({bus.ea, sig_a_s} >= {bus.eb, sig_b_s});
    if (a_is_l_s) begin
      sig_l_s  = sig_a_s;
      sig_sm_s = sig_b_s;
      emax_s   = bus.ea;
      emin_s   = bus.eb;
      sign_l_s = bus.sa;
    end else begin
      sig_l_s  = sig_b_s;
      sig_sm_s = sig_a_s;
      emax_s   = bus.eb;
      emin_s   = bus.ea;
      sign_l_s = sbe_s;
    end
    dexp_s = emax_s - emin_s;
    if (dexp_s >= 8'd24) begin
      sig_al_s = 24'd0;
    end else begin
      sig_al_s = sig_sm_s >> dexp_s;
    end
  end

  // Add/subtract, normalization, zero handling and optional overflow saturation.
  always_comb begin
    sum_s      = {1'b0, sig_l_s} + {1'b0, sig_al_s};
    diff_s     = sig_l_s - sig_al_s;
    lz_s       = lzc24(diff_s);
    shift_s    = 8'd0;
    res_mant_s = 24'd0;
    res_exp_s  = 8'd0;
    res_sign_s = 1'b0;
    res_tc_s   = 1'b0;
    if (!sub_s) begin
      res_tc_s   = sum_s[24];
      res_sign_s = bus.sa;
      if (sum_s[24]) begin
        res_mant_s = sum_s[24:1];
        res_exp_s  = emax_s + 8'd1;
      end else begin
        res_mant_s = sum_s[23:0];
        res_exp_s  = emax_s;
      end
    end else begin
      res_tc_s   = 1'b0;
      res_sign_s = sign_l_s;
      // Normalizing past emax would underflow; stop at exponent 0 instead.
      if ({3'd0, lz_s} > emax_s) begin
        shift_s = emax_s;
      end else begin
        shift_s = {3'd0, lz_s};
      end
      res_mant_s = diff_s << shift_s;
      res_exp_s  = emax_s - shift_s;
    end

    mant_d = res_mant_s;
    exp_d  = res_exp_s;
    sign_d = res_sign_s;
    tc_d   = res_tc_s;
    if (res_mant_s == 24'd0) begin
      mant_d = 24'd0;
      exp_d  = 8'd0;
      sign_d = 1'b0;
    end else begin
`ifdef FP_OVF_SAT_EN
      if (!sub_s && res_tc_s && (emax_s >= 8'd254)) begin
        mant_d = 24'd0;
        exp_d  = 8'hFF;
      end else begin
        mant_d = res_mant_s;
        exp_d  = res_exp_s;
      end
`else
      mant_d = res_mant_s;
      exp_d  = res_exp_s;
`endif
    end
  end

  // Result register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_q <= 24'd0;
      exp_q  <= 8'd0;
      sign_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      mant_q <= mant_d;
      exp_q  <= exp_d;
      sign_q <= sign_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.mant       = mant_q;
  assign bus.exponent   = exp_q;
  assign bus.sign       = sign_q;
  assign bus.totalcarry = tc_q;

endmodule

// File: tb/tb_fp_addsub_main.sv
// Directed bench for fp_addsub_main with hand-computed expectations.
module tb_fp_addsub_main;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_addsub_main_if bus_if ();

  fp_addsub_main dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_res(input string tag, input logic [23:0] e_mant,
                           input logic [7:0] e_exp, input logic e_sign, input logic e_tc);
    checks++;
    assert (bus_if.mant === e_mant) else begin
      errors++;
      $error("FAIL %s mant observed %h expected %h", tag, bus_if.mant, e_mant);
    end
    checks++;
    assert (bus_if.exponent === e_exp) else begin
      errors++;
      $error("FAIL %s exponent observed %h expected %h", tag, bus_if.exponent, e_exp);
    end
    checks++;
    assert (bus_if.sign === e_sign) else begin
      errors++;
      $error("FAIL %s sign observed %b expected %b", tag, bus_if.sign, e_sign);
    end
    checks++;
    assert (bus_if.totalcarry === e_tc) else begin
      errors++;
      $error("FAIL %s totalcarry observed %b expected %b", tag, bus_if.totalcarry, e_tc);
    end
  endtask

  task automatic set_ops(input logic sa, input logic sb, input logic op,
                         input logic [22:0] ma, input logic [22:0] mb,
                         input logic [7:0] ea, input logic [7:0] eb);
    bus_if.sa     = sa;
    bus_if.sb     = sb;
    bus_if.opcode = op;
    bus_if.ma     = ma;
    bus_if.mb     = mb;
    bus_if.ea     = ea;
    bus_if.eb     = eb;
  endtask

  task automatic issue(input logic sa, input logic sb, input logic op,
                       input logic [22:0] ma, input logic [22:0] mb,
                       input logic [7:0] ea, input logic [7:0] eb);
    @(negedge clk);
    set_ops(sa, sb, op, ma, mb, ea, eb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_ops(1'b0, 1'b0, 1'b0, 23'h400000, 23'h0, 8'd1, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    check_res("reset", 24'h000000, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 1'b0, 1'b0, 23'h400000, 23'h000000, 8'd1, 8'd1);
    check_res("add_carry", 24'hA00000, 8'd2, 1'b0, 1'b1);

    issue(1'b0, 1'b0, 1'b0, 23'h000000, 23'h000000, 8'd3, 8'd1);
    check_res("align", 24'hA00000, 8'd3, 1'b0, 1'b0);

    issue(1'b0, 1'b0, 1'b1, 23'h400000, 23'h000000, 8'd5, 8'd5);
    check_res("sub_norm_ab", 24'h800000, 8'd4, 1'b0, 1'b0);

    issue(1'b0, 1'b0, 1'b1, 23'h000000, 23'h400000, 8'd5, 8'd5);
    check_res("sub_norm_ba", 24'h800000, 8'd4, 1'b1, 1'b0);

    issue(1'b0, 1'b0, 1'b1, 23'h123456, 23'h123456, 8'd7, 8'd7);
    check_res("cancel", 24'h000000, 8'd0, 1'b0, 1'b0);

    issue(1'b0, 1'b0, 1'b0, 23'h000000, 23'h000000, 8'd254, 8'd254);
`ifdef FP_OVF_SAT_EN
    check_res("overflow", 24'h000000, 8'hFF, 1'b0, 1'b1);
`else
    check_res("overflow", 24'h800000, 8'hFF, 1'b0, 1'b1);
`endif

    // sb=1 with subtract opcode is an effective add.
    issue(1'b0, 1'b1, 1'b1, 23'h400000, 23'h000000, 8'd1, 8'd1);
    check_res("dbl_neg_add", 24'hA00000, 8'd2, 1'b0, 1'b1);

    issue(1'b1, 1'b1, 1'b0, 23'h000000, 23'h000000, 8'd3, 8'd1);
    check_res("neg_add", 24'hA00000, 8'd3, 1'b1, 1'b0);

    issue(1'b0, 1'b0, 1'b0, 23'h123456, 23'h7FFFFF, 8'd30, 8'd1);
    check_res("far_align", 24'h923456, 8'd30, 1'b0, 1'b0);

    issue(1'b0, 1'b0, 1'b1, 23'h000000, 23'h400000, 8'd1, 8'd0);
    check_res("sub_denorm", 24'hC00000, 8'd0, 1'b0, 1'b0);

    issue(1'b0, 1'b0, 1'b1, 23'h000001, 23'h000000, 8'd1, 8'd1);
    check_res("sub_clamp", 24'h000002, 8'd0, 1'b0, 1'b0);

    // Reset between two issued operations.
    issue(1'b0, 1'b0, 1'b0, 23'h400000, 23'h000000, 8'd1, 8'd1);
    check_res("pre_reset", 24'hA00000, 8'd2, 1'b0, 1'b1);
    @(negedge clk);
    set_ops(1'b0, 1'b0, 1'b0, 23'h000000, 23'h000000, 8'd3, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check_res("async_reset", 24'h000000, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_res("reset_held", 24'h000000, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_res("post_release", 24'h000000, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_res("first_after_reset", 24'hA00000, 8'd3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
